fsk_frame_scheduler: RTL
========================

FSK_FRAME_SCHEDULER -- requirements
Module: fsk_frame_scheduler

Interface
REQ-001 The block SHALL have parameter SYMBOL_LEN, default 256, clock cycles per transmitted bit; legal values 2..65535.
REQ-002 The block SHALL have parameter GAP_LEN, default 256, idle cycles after each byte; legal values 1..65535.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, byte buffer entries; legal values 2, 4 or 8.
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit, the only clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port tx_enable, input, 1 bit, which permits a new frame to start.
REQ-007 The block SHALL have port byte_data, input, 8 bits, the byte to transmit.
REQ-008 The block SHALL have port byte_valid, input, 1 bit, meaning byte_data is offered.
REQ-009 The block SHALL have port byte_ready, output, 1 bit, meaning the FIFO can accept a byte.
REQ-010 The block SHALL have port phase_step, output, 2 bits, the sine-address increment: 0 = hold/idle, 1 = mark (bit 1), 2 = space (bit 0).
REQ-011 The block SHALL have port tx_active, output, 1 bit, high while a bit is being sent.
REQ-012 The block SHALL have port bit_index, output, 3 bits, the index of the bit currently being sent.
REQ-013 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at the end of a byte.
REQ-014 The block SHALL have port fifo_count, output, 4 bits, the number of buffered bytes.

Function
REQ-015 The FIFO SHALL accept byte_data on every edge where byte_valid && byte_ready; byte_ready SHALL equal (fifo_count < FIFO_DEPTH).
REQ-016 When full, byte_ready SHALL be 0, offered bytes SHALL not be written, and no data SHALL be overwritten.
REQ-017 On a simultaneous push and pop, fifo_count SHALL be unchanged and ordering SHALL stay first-in first-out.
REQ-018 The FSM SHALL have states IDLE, LOAD, SEND and GAP, with all outputs registered.
REQ-019 IDLE SHALL go to LOAD when tx_enable=1 && fifo_count>0; otherwise it SHALL stay in IDLE.
REQ-020 LOAD SHALL last one cycle, SHALL pop the head byte into the shift register, SHALL clear bit_index and the symbol counter, and SHALL then go to SEND.
REQ-021 In SEND, bits SHALL be sent LSB first.
REQ-022 In SEND, phase_step SHALL be 1 when the current bit is 1 and 2 when it is 0, and tx_active SHALL be 1.
REQ-023 In SEND, each bit SHALL be held exactly SYMBOL_LEN cycles.
REQ-024 In SEND, the symbol counter SHALL count 0..SYMBOL_LEN-1, and at SYMBOL_LEN-1 bit_index SHALL increment, wrapping 7->0.
REQ-025 At symbol count SYMBOL_LEN-1 with bit_index=7, the FSM SHALL go to GAP, and frame_done SHALL be 1 for exactly the first GAP cycle.
REQ-026 GAP SHALL last GAP_LEN cycles with phase_step=0 and tx_active=0.
REQ-027 At the end of GAP, the FSM SHALL go to LOAD if tx_enable=1 && fifo_count>0, otherwise to IDLE.
REQ-028 Deasserting tx_enable during SEND or GAP SHALL NOT abort the current byte; it SHALL only block the next LOAD.
REQ-029 In IDLE and LOAD, phase_step SHALL be 0, tx_active SHALL be 0, and bit_index SHALL hold 0.
REQ-030 Latency: a byte pushed at edge N into an empty FIFO while in IDLE with tx_enable=1 SHALL give LOAD after edge N+1 and SEND bit 0 after edge N+2.
REQ-031 Total frame time from the first SEND cycle to the first IDLE or LOAD cycle SHALL be 8*SYMBOL_LEN + GAP_LEN cycles.
REQ-032 Counter widths SHALL be 16 bits and the FIFO pointers log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
REQ-033 The internal counter for fifo_count SHALL never exceed FIFO_DEPTH or go below 0.

Reset
REQ-034 Asserting RESET SHALL immediately, without a clock, force state IDLE, phase_step=0, tx_active=0, bit_index=0, frame_done=0, fifo_count=0 and byte_ready=1, and SHALL clear all counters and pointers.
REQ-035 Reset during SEND or GAP SHALL abort the byte and flush the FIFO, and SHALL NOT produce a frame_done pulse.
REQ-036 After RESET deasserts, the first push SHALL be accepted on the next rising edge.

Verification (SYMBOL_LEN=4, GAP_LEN=2, FIFO_DEPTH=4)
REQ-037 A push of 0xAC with tx_enable=1 SHALL produce the phase_step sequence 2,2,1,1,2,1,2,1, each value held 4 cycles, then 0 for 2 cycles with frame_done high in the first of those, then IDLE.
REQ-038 Back-to-back pushes of 0xFF and 0x00 SHALL give 32 cycles of step 1, 2 gap cycles, a LOAD cycle, 32 cycles of step 2, 2 gap cycles, then IDLE.
REQ-039 Six pushes with tx_enable=0 SHALL leave fifo_count=4 with byte_ready=0 after the fourth push, drop pushes 5 and 6, and give phase_step=0 throughout.
REQ-040 Dropping tx_enable at bit 3 of a frame, with 2 bytes queued, SHALL complete the frame, return to IDLE after GAP, and keep fifo_count=2.
REQ-041 A RESET pulse at bit 5 SHALL immediately give phase_step=0, fifo_count=0 and no frame_done, and a new push of 0x01 SHALL start SEND 2 edges later with step 1.
REQ-042 A push and a LOAD pop on the same edge with fifo_count=2 SHALL leave fifo_count=2, and the popped byte SHALL be the oldest entry.

Source files
------------

// File: rtl/fsk_frame_scheduler.sv
// FSK byte scheduler: buffers bytes in a small FIFO and sends each one LSB first as
// mark/space phase steps held SYMBOL_LEN cycles, followed by a GAP_LEN idle gap.
//
// state | meaning
// IDLE  | waiting for tx_enable with a buffered byte
// LOAD  | pop head byte into the shift register (one cycle)
// SEND  | drive mark/space for the current bit, SYMBOL_LEN cycles per bit
// GAP   | inter-byte silence, GAP_LEN cycles
module fsk_frame_scheduler #(
  parameter int SYMBOL_LEN = 256,
  parameter int GAP_LEN    = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       tx_enable,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [1:0] phase_step,
  output logic       tx_active,
  output logic [2:0] bit_index,
  output logic       frame_done,
  output logic [3:0] fifo_count
);

  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_C    = 4'(FIFO_DEPTH);
  localparam logic [15:0] SYM_LAST   = 16'(SYMBOL_LEN - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_LEN - 1);
  localparam logic [1:0]  STEP_IDLE  = 2'd0;
  localparam logic [1:0]  STEP_MARK  = 2'd1;
  localparam logic [1:0]  STEP_SPACE = 2'd2;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [3:0]       r_count;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [15:0]      r_sym_cnt, w_sym_nxt;
  logic [15:0]      r_gap_cnt, w_gap_nxt;
  logic [2:0]       r_bit_idx, w_bit_nxt;
  logic [1:0]       r_step, w_step_nxt;
  logic             r_active, w_active_nxt;
  logic             r_done, w_done_nxt;
  logic             w_push, w_pop;
  logic [7:0]       w_head;
  logic [2:0]       w_bit_inc;

  assign byte_ready = (r_count < DEPTH_C);
  assign w_push     = byte_valid && byte_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_inc  = r_bit_idx + 3'd1;

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= byte_data;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_sym_cnt <= '0;
      r_gap_cnt <= '0;
      r_bit_idx <= '0;
      r_step    <= STEP_IDLE;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_sym_cnt <= w_sym_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_bit_idx <= w_bit_nxt;
      r_step    <= w_step_nxt;
      r_active  <= w_active_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Outputs are computed one cycle ahead so they are registered with the state.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_sym_nxt    = r_sym_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_bit_nxt    = r_bit_idx;
    w_step_nxt   = STEP_IDLE;
    w_active_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_nxt = '0;
        if (tx_enable && (r_count != 4'd0)) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_pop        = 1'b1;
        w_shift_nxt  = w_head;
        w_sym_nxt    = '0;
        w_bit_nxt    = '0;
        w_step_nxt   = w_head[0] ? STEP_MARK : STEP_SPACE;
        w_active_nxt = 1'b1;
        w_state_nxt  = SEND;
      end
      SEND: begin
        if (r_sym_cnt == SYM_LAST) begin
          w_sym_nxt = '0;
          w_bit_nxt = w_bit_inc;
          if (r_bit_idx == 3'd7) begin
            w_gap_nxt   = GAP_LAST;
            w_done_nxt  = 1'b1;
            w_state_nxt = GAP;
          end else begin
            w_step_nxt   = r_shift[w_bit_inc] ? STEP_MARK : STEP_SPACE;
            w_active_nxt = 1'b1;
          end
        end else begin
          w_sym_nxt    = r_sym_cnt + 16'd1;
          w_step_nxt   = r_shift[r_bit_idx] ? STEP_MARK : STEP_SPACE;
          w_active_nxt = 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == 16'd0) begin
          w_state_nxt = (tx_enable && (r_count != 4'd0)) ? LOAD : IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign phase_step = r_step;
  assign tx_active  = r_active;
  assign bit_index  = r_bit_idx;
  assign frame_done = r_done;
  assign fifo_count = r_count;

endmodule
